// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode map, sequencer state encoding and opcode classifiers
//               shared by the ALU accumulator wrappers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_PASS    = 4'h0;
    localparam logic [3:0] OP_INC     = 4'h1;
    localparam logic [3:0] OP_ADD     = 4'h2;
    localparam logic [3:0] OP_SUB     = 4'h3;
    localparam logic [3:0] OP_DEC     = 4'h4;
    localparam logic [3:0] OP_NOT     = 4'h5;
    localparam logic [3:0] OP_AND     = 4'h6;
    localparam logic [3:0] OP_NAND    = 4'h7;
    localparam logic [3:0] OP_OR      = 4'h8;
    localparam logic [3:0] OP_NOR     = 4'h9;
    localparam logic [3:0] OP_XOR     = 4'hA;
    localparam logic [3:0] OP_XNOR    = 4'hB;
    localparam logic [3:0] OP_GT      = 4'hC;
    localparam logic [3:0] OP_LT      = 4'hD;
    localparam logic [3:0] OP_EQ      = 4'hE;
    localparam logic [3:0] OP_ILLEGAL = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Only add/sub report a meaningful overflow from the ALU.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_cmp(input logic [3:0] op);
        return (op == OP_GT) || (op == OP_LT) || (op == OP_EQ);
    endfunction

    function automatic logic is_alu_write(input logic [3:0] op);
        logic w;
        case (op)
            OP_PASS, OP_INC, OP_ADD, OP_SUB, OP_DEC, OP_NOT,
            OP_AND, OP_NAND, OP_OR, OP_NOR, OP_XOR, OP_XNOR: w = 1'b1;
            default:                                         w = 1'b0;
        endcase
        return w;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_unit
// Description : Zero detect on the registered result and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_unit #(
    parameter int W         = 8,
    parameter int STICKY_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_en,
    input  logic         of_in,
    input  logic         clr_sticky,
    input  logic [W-1:0] res_data,
    output logic         res_zero,
    output logic         of_sticky
);

    assign res_zero = (res_data == '0);

    generate
        if (STICKY_EN != 0) begin : g_sticky
            logic sticky_q;
            logic sticky_d;

            // A capture with overflow beats a simultaneous clear.
            always_comb begin
                sticky_d = sticky_q;
                if (cap_en && of_in) begin
                    sticky_d = 1'b1;
                end else if (clr_sticky) begin
                    sticky_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_q <= 1'b0;
                end else begin
                    sticky_q <= sticky_d;
                end
            end

            assign of_sticky = sticky_q;
        end else begin : g_no_sticky
            assign of_sticky = 1'b0;
        end
    endgenerate

endmodule : alu_flag_unit
`default_nettype wire

// File: rtl/alu_acc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_acc_sequencer
// Description : Handshaked accumulator sequencer driving an external 8-bit ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_acc_sequencer
    import alu_pkg::*;
#(
    parameter int W              = 8,
    parameter int CMP_WRITES_ACC = 0,
    parameter int STICKY_EN      = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic         cmd_load,
    input  logic [W-1:0] cmd_operand,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_out,
    input  logic         alu_of,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_of,
    output logic         res_zero,
    output logic         res_err,
    output logic [W-1:0] acc_out,
    output logic         of_sticky,
    input  logic         clr_sticky
);

    seq_state_e   state_q,    state_d;
    logic [3:0]   op_q,       op_d;
    logic [W-1:0] operand_q,  operand_d;
    logic         load_q,     load_d;
    logic [W-1:0] acc_q,      acc_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_of_q,   res_of_d;
    logic         res_err_q,  res_err_d;
    logic         cap_en;

    // Gating with rst_n keeps ready low for the whole reset assertion.
    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign res_valid = (state_q == ST_DONE);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        operand_d  = operand_q;
        load_d     = load_q;
        acc_d      = acc_q;
        res_data_d = res_data_q;
        res_of_d   = res_of_q;
        res_err_d  = res_err_q;
        cap_en     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d      = cmd_op;
                    operand_d = cmd_operand;
                    load_d    = cmd_load;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cap_en  = 1'b1;
                state_d = ST_DONE;
                if (load_q) begin
                    acc_d      = operand_q;
                    res_data_d = operand_q;
                    res_of_d   = 1'b0;
                    res_err_d  = 1'b0;
                end else if (op_q == OP_ILLEGAL) begin
                    // ALU output is undefined for this opcode, so it is never sampled.
                    res_data_d = acc_q;
                    res_of_d   = 1'b0;
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = alu_out;
                    res_of_d   = alu_of & is_arith(op_q);
                    res_err_d  = 1'b0;
                    if (is_alu_write(op_q) || (is_cmp(op_q) && (CMP_WRITES_ACC != 0))) begin
                        acc_d = alu_out;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            operand_q  <= '0;
            load_q     <= 1'b0;
            acc_q      <= '0;
            res_data_q <= '0;
            res_of_q   <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            operand_q  <= operand_d;
            load_q     <= load_d;
            acc_q      <= acc_d;
            res_data_q <= res_data_d;
            res_of_q   <= res_of_d;
            res_err_q  <= res_err_d;
        end
    end

    alu_flag_unit #(
        .W         (W),
        .STICKY_EN (STICKY_EN)
    ) u_flags (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_en     (cap_en),
        .of_in      (res_of_d),
        .clr_sticky (clr_sticky),
        .res_data   (res_data_q),
        .res_zero   (res_zero),
        .of_sticky  (of_sticky)
    );

    assign alu_a    = acc_q;
    assign alu_b    = operand_q;
    assign alu_op   = op_q;
    assign res_data = res_data_q;
    assign res_of   = res_of_q;
    assign res_err  = res_err_q;
    assign acc_out  = acc_q;

endmodule : alu_acc_sequencer
`default_nettype wire
